// File: rtl/spreader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spreader_pkg
// Purpose  : Shared constants for the symbol spreader (chip table, FSM codes).
// Revision : 1.0
// ============================================================================
package spreader_pkg;

    localparam int unsigned c_sym_w    = 4;
    localparam int unsigned c_chip_cnt = 32;
    localparam int unsigned c_idx_w    = 5;

    localparam logic [c_idx_w-1:0] c_last_idx = 5'd31;

    // Base PN sequence for symbol 0; c0 sits in the MSB.
    localparam logic [c_chip_cnt-1:0] c_base_chips = 32'b11011001110000110101001000101110;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_send  = 2'd1;
    localparam logic [1:0] c_st_stall = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pn_chip_map.sv
`default_nettype none
// ============================================================================
// Module   : pn_chip_map
// Purpose  : Combinational lookup of one chip of a 4-bit symbol's PN sequence.
// Revision : 1.0
// ============================================================================
module pn_chip_map
    import spreader_pkg::*;
(
    input  logic [c_sym_w-1:0] symbol,
    input  logic [c_idx_w-1:0] idx,
    output logic               chip
);

    logic [c_idx_w-1:0] w_shift;
    logic [c_idx_w-1:0] w_pos;
    logic [c_idx_w-1:0] w_bit;

    // Symbols 1..7 rotate right by 4k chips; symbols 8..15 also flip odd chips.
    always_comb begin
        w_shift = {symbol[2:0], 2'b00};
        w_pos   = idx - w_shift;
        w_bit   = c_last_idx - w_pos;
        chip    = c_base_chips[w_bit] ^ (symbol[3] & idx[0]);
    end

endmodule
`default_nettype wire

// File: rtl/symbol_spreader.sv
`default_nettype none
// ============================================================================
// Module   : symbol_spreader
// Purpose  : Splits framed bytes into nibble symbols and emits their PN chips.
// Revision : 1.0
// ============================================================================
module symbol_spreader
    import spreader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    input  logic       chip_en,
    output logic       chip_out,
    output logic       chip_valid,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    logic [1:0]         r_state_q,     w_state_d;
    logic [c_idx_w-1:0] r_chip_idx_q,  w_chip_idx_d;
    logic               r_nib_q,       w_nib_d;
    logic [7:0]         r_hold_data_q, w_hold_data_d;
    logic               r_hold_valid_q, w_hold_valid_d;
    logic               r_hold_last_q, w_hold_last_d;
    logic [7:0]         r_act_data_q,  w_act_data_d;
    logic               r_act_valid_q, w_act_valid_d;
    logic               r_act_last_q,  w_act_last_d;
    logic               r_last_seen_q, w_last_seen_d;
    logic               r_done_q,      w_done_d;
    logic               r_underrun_q,  w_underrun_d;

    logic               w_advance, w_wrap, w_retire, w_accept, w_free, w_load;
    logic [c_sym_w-1:0] w_symbol;
    logic               w_map_chip;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= c_st_idle;
            r_chip_idx_q   <= '0;
            r_nib_q        <= 1'b0;
            r_hold_data_q  <= '0;
            r_hold_valid_q <= 1'b0;
            r_hold_last_q  <= 1'b0;
            r_act_data_q   <= '0;
            r_act_valid_q  <= 1'b0;
            r_act_last_q   <= 1'b0;
            r_last_seen_q  <= 1'b0;
            r_done_q       <= 1'b0;
            r_underrun_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_chip_idx_q   <= w_chip_idx_d;
            r_nib_q        <= w_nib_d;
            r_hold_data_q  <= w_hold_data_d;
            r_hold_valid_q <= w_hold_valid_d;
            r_hold_last_q  <= w_hold_last_d;
            r_act_data_q   <= w_act_data_d;
            r_act_valid_q  <= w_act_valid_d;
            r_act_last_q   <= w_act_last_d;
            r_last_seen_q  <= w_last_seen_d;
            r_done_q       <= w_done_d;
            r_underrun_q   <= w_underrun_d;
        end
    end

    always_comb begin
        w_advance = (r_state_q == c_st_send) && chip_en;
        w_wrap    = w_advance && (r_chip_idx_q == c_last_idx);
        w_retire  = w_wrap && r_nib_q;
        // No new byte is taken once the frame's last byte is in the pipeline.
        w_accept  = din_valid && !r_hold_valid_q && !r_last_seen_q;
        w_free    = !r_act_valid_q || w_retire;
        w_load    = w_free && (r_hold_valid_q || w_accept);

        w_state_d      = r_state_q;
        w_chip_idx_d   = r_chip_idx_q;
        w_nib_d        = r_nib_q;
        w_hold_data_d  = r_hold_data_q;
        w_hold_valid_d = r_hold_valid_q;
        w_hold_last_d  = r_hold_last_q;
        w_act_data_d   = r_act_data_q;
        w_act_valid_d  = r_act_valid_q;
        w_act_last_d   = r_act_last_q;
        w_last_seen_d  = r_last_seen_q || (w_accept && din_last);
        w_done_d       = 1'b0;
        w_underrun_d   = r_underrun_q;

        // Byte buffers: a byte bypasses hold when hold is empty and active frees up.
        if (w_load) begin
            w_act_valid_d = 1'b1;
            w_act_data_d  = r_hold_valid_q ? r_hold_data_q : din;
            w_act_last_d  = r_hold_valid_q ? r_hold_last_q : din_last;
        end else if (w_retire) begin
            w_act_valid_d = 1'b0;
        end

        if (w_accept && !(w_load && !r_hold_valid_q)) begin
            w_hold_valid_d = 1'b1;
            w_hold_data_d  = din;
            w_hold_last_d  = din_last;
        end else if (w_load && r_hold_valid_q) begin
            w_hold_valid_d = 1'b0;
        end

        case (r_state_q)
            c_st_idle: begin
                if (w_load) begin
                    w_state_d    = c_st_send;
                    w_chip_idx_d = '0;
                    w_nib_d      = 1'b0;
                end
            end
            c_st_send: begin
                if (w_advance) begin
                    w_chip_idx_d = r_chip_idx_q + 5'd1;
                    if (w_wrap) begin
                        w_nib_d = !r_nib_q;
                        if (r_nib_q && !w_load) begin
                            w_state_d = c_st_stall;
                        end
                    end
                end
            end
            c_st_stall: begin
                if (w_load) begin
                    w_state_d    = c_st_send;
                    w_chip_idx_d = '0;
                    w_nib_d      = 1'b0;
                end
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase

        if (w_retire && r_act_last_q) begin
            w_state_d      = c_st_idle;
            w_chip_idx_d   = '0;
            w_nib_d        = 1'b0;
            w_act_valid_d  = 1'b0;
            w_hold_valid_d = 1'b0;
            w_last_seen_d  = 1'b0;
            w_done_d       = 1'b1;
        end

        if (w_state_d == c_st_stall) begin
            w_underrun_d = 1'b1;
        end
    end

    always_comb begin
        w_symbol   = r_nib_q ? r_act_data_q[7:4] : r_act_data_q[3:0];
        chip_valid = (r_state_q == c_st_send);
        chip_out   = chip_valid & w_map_chip;
        busy       = (r_state_q != c_st_idle);
        done       = r_done_q;
        underrun   = r_underrun_q;
        din_ready  = !r_hold_valid_q && !r_last_seen_q;
    end

    pn_chip_map u_pn_chip_map (
        .symbol (w_symbol),
        .idx    (r_chip_idx_q),
        .chip   (w_map_chip)
    );

endmodule
`default_nettype wire

// File: tb/tb_symbol_spreader.sv
`default_nettype none
// ============================================================================
// Module   : tb_symbol_spreader
// Purpose  : Directed self-checking bench for symbol_spreader.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_symbol_spreader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;
    logic       chip_en;
    logic       chip_out;
    logic       chip_valid;
    logic       busy;
    logic       done;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    logic [127:0] acc_v;
    logic         acc_allv;
    logic         any_v;
    logic         hold_ok;
    logic         first;

    localparam logic [31:0] c_base = 32'b11011001110000110101001000101110;

    always #5 clk = ~clk;

    symbol_spreader dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .chip_en    (chip_en),
        .chip_out   (chip_out),
        .chip_valid (chip_valid),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    // Expected chips of a symbol, c0 in the MSB.
    function automatic logic [31:0] sym_seq(input int k);
        logic [31:0] s;
        s = c_base;
        for (int r = 0; r < (k % 8); r++) s = {s[3:0], s[31:4]};
        if (k >= 8) s = s ^ 32'h5555_5555;
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acc();
        acc_v    = '0;
        acc_allv = 1'b1;
    endtask

    task automatic run_chips(input int n);
        for (int i = 0; i < n; i++) begin
            acc_allv = acc_allv & chip_valid;
            acc_v    = {acc_v[126:0], chip_out};
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; din = 8'h00; din_valid = 1'b0; din_last = 1'b0; chip_en = 1'b0;
        tick();
        tick();
        check("rst_ready",    din_ready,  1'b1);
        check("rst_valid",    chip_valid, 1'b0);
        check("rst_chip",     chip_out,   1'b0);
        check("rst_busy",     busy,       1'b0);
        check("rst_done",     done,       1'b0);
        check("rst_underrun", underrun,   1'b0);
        reset = 1'b0;

        // Byte 0x00 last: base sequence twice
        din = 8'h00; din_valid = 1'b1; din_last = 1'b1; chip_en = 1'b1;
        tick();
        din_valid = 1'b0;
        check("t1_ready_after_last", din_ready, 1'b0);
        check("t1_busy", busy, 1'b1);
        clear_acc();
        run_chips(64);
        check("t1_chips", acc_v[63:0], {c_base, c_base});
        check("t1_allvalid", acc_allv, 1'b1);
        check("t1_done", done, 1'b1);
        check("t1_busy_fall", busy, 1'b0);
        tick();
        check("t1_done_pulse", done, 1'b0);
        check("t1_ready_again", din_ready, 1'b1);

        // Back-to-back 0x12, 0x34 with din_valid held high
        clear_acc();
        din = 8'h12; din_valid = 1'b1; din_last = 1'b0;
        tick();
        din = 8'h34; din_last = 1'b1;
        check("t3_ready_hold_empty", din_ready, 1'b1);
        run_chips(1);
        check("t3_ready_hold_full", din_ready, 1'b0);
        run_chips(125);
        check("t3_ready_after_last", din_ready, 1'b0);
        din_valid = 1'b0;
        run_chips(2);
        check("t3_chips", acc_v, {sym_seq(2), sym_seq(1), sym_seq(4), sym_seq(3)});
        check("t3_contiguous", acc_allv, 1'b1);
        check("t3_done", done, 1'b1);
        tick();

        // Second byte withheld: stall and underrun
        clear_acc();
        din = 8'h12; din_valid = 1'b1; din_last = 1'b0;
        tick();
        din_valid = 1'b0;
        run_chips(64);
        check("t4_first_chips", acc_v[63:0], {sym_seq(2), sym_seq(1)});
        check("t4_stall_valid", chip_valid, 1'b0);
        check("t4_underrun", underrun, 1'b1);
        check("t4_busy", busy, 1'b1);
        any_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            any_v = any_v | chip_valid | chip_out;
            tick();
        end
        check("t4_stall_quiet", any_v, 1'b0);
        din = 8'h34; din_valid = 1'b1; din_last = 1'b1;
        tick();
        din_valid = 1'b0;
        clear_acc();
        run_chips(64);
        check("t4_resume_chips", acc_v[63:0], {sym_seq(4), sym_seq(3)});
        check("t4_resume_valid", acc_allv, 1'b1);
        check("t4_done", done, 1'b1);
        check("t4_underrun_sticky", underrun, 1'b1);
        tick();

        // Reset mid-frame at chip 17
        din = 8'h00; din_valid = 1'b1; din_last = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        check("t6_chip17", chip_out, c_base[31-17]);
        reset = 1'b1;
        tick();
        check("t6_valid", chip_valid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_ready", din_ready, 1'b1);
        check("t6_underrun", underrun, 1'b0);
        check("t6_chip", chip_out, 1'b0);
        reset = 1'b0;
        tick();
        check("t6_idle_chip_en", chip_valid, 1'b0);

        // Byte 0xA7 last, clean restart after reset
        din = 8'hA7; din_valid = 1'b1; din_last = 1'b1;
        tick();
        din_valid = 1'b0;
        clear_acc();
        run_chips(64);
        check("t2_chips", acc_v[63:0],
              64'b1001110000110101001000101110110101111011100011001001011000000111);
        check("t2_done", done, 1'b1);
        tick();

        // Byte 0xFF with chip_en 1-in-4
        chip_en = 1'b0;
        din = 8'hFF; din_valid = 1'b1; din_last = 1'b1;
        tick();
        din_valid = 1'b0;
        clear_acc();
        hold_ok = 1'b1;
        for (int j = 0; j < 64; j++) begin
            first    = chip_out;
            acc_allv = acc_allv & chip_valid;
            acc_v    = {acc_v[126:0], chip_out};
            for (int p = 0; p < 4; p++) begin
                chip_en = (p == 3);
                if (chip_out !== first || chip_valid !== 1'b1) hold_ok = 1'b0;
                tick();
            end
        end
        chip_en = 1'b0;
        check("t5_chips", acc_v[63:0], {sym_seq(15), sym_seq(15)});
        check("t5_hold", hold_ok, 1'b1);
        check("t5_valid", acc_allv, 1'b1);
        check("t5_done", done, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
